multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Parametrised multi-cycle main control FSM for the RV32 core with F-extension and UART byte I/O. It sequences fetch, decode, execute, memory access and writeback, and drives every datapath enable and mux select. Compared with the previous decoder it adds:
- configurable memory latency, or a mem_ready handshake;
- timeouts on the UART and FPU busy-waits;
- illegal-opcode trapping;
- a halt request;
- a retired-instruction counter.

Parameters:
MEM_LAT, 2, fixed memory latency in cycles (>=1); used when USE_READY=0
USE_READY, 0, 1: fetch/load waits end on mem_ready instead of the MEM_LAT counter
TIMEOUT, 0, max cycles in UART_WAIT or FTEXECUTE before trap; 0 disables the timeout
CNT_W, 32, width of the retired counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
op  in  7  opcode from instruction register
mem_ready  in  1  memory data valid (USE_READY=1 only)
uart_done  in  1  UART transfer complete
flpt_done  in  1  FPU op complete
halt_req  in  1  request to stop at the next instruction boundary
pcwrite, memwrite, irwrite, regwrite, fregwrite, pcbufwrite, iord, branch, uart_go, rors, iorf, indecode  out  1 each  datapath controls
alusrca, alusrcb, pcsrc  out  2 each  mux selects
regsrc, aluop  out  3 each  writeback source, ALU op class
halted  out  1  in HALT state
illegal_op  out  1  sticky: trapped on undefined opcode
timeout_err  out  1  sticky: trapped on wait timeout
retired  out  CNT_W  completed-instruction count

Behaviour:
Opcodes:
- RTYPE 0110011, ITYPE 0010011, BTYPE 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
- LW 0000011, SW 0100011, FLW 0000111, FSW 0100111, FTYPE 1010011
- RECVB 0000001, SENDB 0000010

Reset:
- While rstn=0: state=FETCH, wait/timeout counters=0, retired=0, sticky flags=0.
- While rstn=0, all outputs are forced to 0. Outputs are state decode gated by rstn.

Transitions:
- FETCH -> FETCH_WAIT -> DECODE.
- DECODE by op:
  - LW/SW/FLW/FSW -> MEMADR
  - RTYPE -> EXECUTE -> ALUWB
  - BTYPE -> BRANCH
  - ITYPE -> IMMEX -> IMMWB
  - LUI -> LUIEX; AUIPC -> AUIPCEX; JAL -> JALEX; JALR -> JALREX
  - SENDB -> SENDB_GO -> UART_WAIT
  - RECVB -> RECVB_GO -> UART_WAIT -> RECVB_WRITE
  - FTYPE -> FTEXECUTE
  - any other op -> TRAP, illegal_op<=1
- MEMADR: loads -> MEM_WAIT -> MEMWB (LW) or FMEMWB (FLW); stores -> MEMWRITE.
- All final states -> FETCH.
- FTEXECUTE and UART_WAIT hold until flpt_done / uart_done respectively.

Memory waits:
- FETCH_WAIT and MEM_WAIT last exactly MEM_LAT cycles (USE_READY=0).
- With USE_READY=1 they last until the cycle mem_ready=1 (inclusive), no upper bound.
- irwrite is asserted only in the final FETCH_WAIT cycle.
- MEM_LAT=2 gives the legacy fetch timing.

Timeout (TIMEOUT>0):
- The counter clears on entry to UART_WAIT/FTEXECUTE and increments each cycle spent there.
- If done=0 in the TIMEOUT-th cycle, next state is TRAP and timeout_err<=1.
- done=1 in that same cycle wins: normal exit.

TRAP: absorbing until reset; all enables 0.

Halt and retire:
- On any transition that would enter FETCH, go to HALT instead if halt_req=1.
- HALT: halted=1, all enables 0; exits to FETCH the cycle after halt_req=0.
- retired increments by 1 on every exit from a final state (into FETCH or HALT); wraps modulo 2^CNT_W.

Outputs per state (unlisted = 0):
- FETCH: pcwrite, pcbufwrite, alusrcb=01
- DECODE: alusrca=01, alusrcb=10, indecode
- MEMADR: alusrca=10, alusrcb=10
- MEM_WAIT: iord
- MEMWB: regwrite, regsrc=001
- FMEMWB: fregwrite
- MEMWRITE: memwrite, iord, iorf=(op==FSW)
- EXECUTE: alusrca=10, aluop=100
- ALUWB, IMMWB, AUIPCEX: regwrite
- BRANCH: alusrca=10, pcsrc=01, branch, aluop=111
- IMMEX: alusrca=10, alusrcb=10, aluop=101
- LUIEX: regwrite, regsrc=010
- JALEX: pcwrite, regwrite, regsrc=011, pcsrc=01
- JALREX: pcwrite, regwrite, alusrca=10, alusrcb=10, regsrc=011, pcsrc=10
- SENDB_GO: uart_go, rors
- RECVB_GO: uart_go
- RECVB_WRITE: regwrite, regsrc=100

Test Plan:
- MEM_LAT=3, op=RTYPE: FETCH, 3 FETCH_WAIT cycles with irwrite only in the 3rd, DECODE, EXECUTE (aluop=100), ALUWB (regwrite), FETCH; retired 0->1.
- USE_READY=1, op=FLW, mem_ready raised 5 cycles into MEM_WAIT: iord held 5 cycles, then FMEMWB with fregwrite=1 for one cycle, regwrite=0.
- TIMEOUT=4, op=FTYPE, flpt_done never set: 4 FTEXECUTE cycles -> TRAP, timeout_err=1 stays set; retired unchanged. Repeat with flpt_done=1 in cycle 4 -> FETCH, no error.
- op=7'b1111111 in DECODE -> TRAP, illegal_op=1, all enables 0 for 100 cycles; rstn pulse low mid-TRAP -> outputs 0 immediately, flags cleared, FETCH resumes.
- halt_req=1 during IMMWB -> HALT with halted=1 and retired incremented; halt_req=0 -> FETCH next cycle.
- op=FSW: MEMWRITE cycle has memwrite=1, iord=1, iorf=1; op=SW: iorf=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the RV32F core with UART byte I/O.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_ctrl #(
  parameter int MEM_LAT   = 2,
  parameter int USE_READY = 0,
  parameter int TIMEOUT   = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  input  logic             uart_done,
  input  logic             flpt_done,
  input  logic             halt_req,
  output logic             pcwrite,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             fregwrite,
  output logic             pcbufwrite,
  output logic             iord,
  output logic             branch,
  output logic             uart_go,
  output logic             rors,
  output logic             iorf,
  output logic             indecode,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       regsrc,
  output logic [2:0]       aluop,
  output logic             halted,
  output logic             illegal_op,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_FLW   = 7'b0000111;
  localparam logic [6:0] OP_FSW   = 7'b0100111;
  localparam logic [6:0] OP_FTYPE = 7'b1010011;
  localparam logic [6:0] OP_RECVB = 7'b0000001;
  localparam logic [6:0] OP_SENDB = 7'b0000010;

  localparam int WMAX = (MEM_LAT > TIMEOUT) ? MEM_LAT : TIMEOUT;
  localparam int WCW  = $clog2(WMAX + 1);

  typedef enum logic [4:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_MEMADR, S_MEM_WAIT, S_MEMWB, S_FMEMWB,
    S_MEMWRITE, S_EXECUTE, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_LUIEX,
    S_AUIPCEX, S_JALEX, S_JALREX, S_SENDB_GO, S_RECVB_GO, S_UART_WAIT,
    S_RECVB_WRITE, S_FTEXECUTE, S_TRAP, S_HALT
  } state_t;

  state_t             state_q, state_d, fetch_nxt;
  logic [WCW-1:0]     cnt_q, cnt_d;
  logic               ill_q, ill_d, tmo_q, tmo_d;
  logic [CNT_W-1:0]   retired_q;
  logic               retire, mem_done, wait_expired;

  // cnt_q counts cycles already spent in the current wait state (0 in the first one)
  assign mem_done     = (USE_READY != 0) ? mem_ready : (cnt_q == WCW'(MEM_LAT - 1));
  assign wait_expired = (TIMEOUT > 0) && (cnt_q == WCW'(TIMEOUT - 1));
  assign fetch_nxt    = halt_req ? S_HALT : S_FETCH;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ill_d   = ill_q;
    tmo_d   = tmo_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: if (mem_done) state_d = S_DECODE;
                    else cnt_d = cnt_q + WCW'(1);
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW, OP_FLW, OP_FSW: state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXECUTE;
          OP_BTYPE: state_d = S_BRANCH;
          OP_ITYPE: state_d = S_IMMEX;
          OP_LUI:   state_d = S_LUIEX;
          OP_AUIPC: state_d = S_AUIPCEX;
          OP_JAL:   state_d = S_JALEX;
          OP_JALR:  state_d = S_JALREX;
          OP_SENDB: state_d = S_SENDB_GO;
          OP_RECVB: state_d = S_RECVB_GO;
          OP_FTYPE: state_d = S_FTEXECUTE;
          default: begin
            state_d = S_TRAP;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW || op == OP_FLW) ? S_MEM_WAIT : S_MEMWRITE;
      S_MEM_WAIT: if (mem_done) state_d = (op == OP_FLW) ? S_FMEMWB : S_MEMWB;
                  else cnt_d = cnt_q + WCW'(1);
      S_EXECUTE:  state_d = S_ALUWB;
      S_IMMEX:    state_d = S_IMMWB;
      S_SENDB_GO, S_RECVB_GO: state_d = S_UART_WAIT;
      // A SENDB completes in UART_WAIT; a RECVB still has to write the byte back
      S_UART_WAIT: begin
        if (uart_done) begin
          if (op == OP_RECVB) state_d = S_RECVB_WRITE;
          else begin
            state_d = fetch_nxt;
            retire  = 1'b1;
          end
        end else if (wait_expired) begin
          state_d = S_TRAP;
          tmo_d   = 1'b1;
        end else cnt_d = cnt_q + WCW'(1);
      end
      S_FTEXECUTE: begin
        if (flpt_done) begin
          state_d = fetch_nxt;
          retire  = 1'b1;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          tmo_d   = 1'b1;
        end else cnt_d = cnt_q + WCW'(1);
      end
      S_MEMWB, S_FMEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_IMMWB, S_LUIEX,
      S_AUIPCEX, S_JALEX, S_JALREX, S_RECVB_WRITE: begin
        state_d = fetch_nxt;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      S_HALT:  if (!halt_req) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      ill_q     <= 1'b0;
      tmo_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      tmo_q   <= tmo_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outputs are a pure state decode, forced low while rstn is asserted
  always_comb begin
    pcwrite = 1'b0; memwrite = 1'b0; irwrite = 1'b0; regwrite = 1'b0;
    fregwrite = 1'b0; pcbufwrite = 1'b0; iord = 1'b0; branch = 1'b0;
    uart_go = 1'b0; rors = 1'b0; iorf = 1'b0; indecode = 1'b0; halted = 1'b0;
    alusrca = 2'b00; alusrcb = 2'b00; pcsrc = 2'b00; regsrc = 3'b000; aluop = 3'b000;
    if (rstn) begin
      case (state_q)
        S_FETCH:      begin pcwrite = 1'b1; pcbufwrite = 1'b1; alusrcb = 2'b01; end
        S_FETCH_WAIT: irwrite = mem_done;
        S_DECODE:     begin alusrca = 2'b01; alusrcb = 2'b10; indecode = 1'b1; end
        S_MEMADR:     begin alusrca = 2'b10; alusrcb = 2'b10; end
        S_MEM_WAIT:   iord = 1'b1;
        S_MEMWB:      begin regwrite = 1'b1; regsrc = 3'b001; end
        S_FMEMWB:     fregwrite = 1'b1;
        S_MEMWRITE:   begin memwrite = 1'b1; iord = 1'b1; iorf = (op == OP_FSW); end
        S_EXECUTE:    begin alusrca = 2'b10; aluop = 3'b100; end
        S_ALUWB, S_IMMWB, S_AUIPCEX: regwrite = 1'b1;
        S_BRANCH: begin
          alusrca = 2'b10; pcsrc = 2'b01; branch = 1'b1; aluop = 3'b111;
        end
        S_IMMEX:      begin alusrca = 2'b10; alusrcb = 2'b10; aluop = 3'b101; end
        S_LUIEX:      begin regwrite = 1'b1; regsrc = 3'b010; end
        S_JALEX: begin
          pcwrite = 1'b1; regwrite = 1'b1; regsrc = 3'b011; pcsrc = 2'b01;
        end
        S_JALREX: begin
          pcwrite = 1'b1; regwrite = 1'b1; alusrca = 2'b10; alusrcb = 2'b10;
          regsrc = 3'b011; pcsrc = 2'b10;
        end
        S_SENDB_GO:    begin uart_go = 1'b1; rors = 1'b1; end
        S_RECVB_GO:    uart_go = 1'b1;
        S_RECVB_WRITE: begin regwrite = 1'b1; regsrc = 3'b100; end
        S_HALT:        halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal_op  = ill_q & rstn;
  assign timeout_err = tmo_q & rstn;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: fixed-latency/timeout instance (A) and mem_ready instance (B),
// driven from a vector table with an expected-output queue.
module tb_multicycle_ctrl;

  localparam logic [6:0] RTYPE = 7'b0110011, ITYPE = 7'b0010011, BTYPE = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111, SW = 7'b0100011, FSW = 7'b0100111;
  localparam logic [6:0] FLW = 7'b0000111, FTYPE = 7'b1010011, SENDB = 7'b0000010;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic pcwrite, memwrite, irwrite, regwrite, fregwrite, pcbufwrite;
    logic iord, branch, uart_go, rors, iorf, indecode;
    logic [1:0] alusrca, alusrcb, pcsrc;
    logic [2:0] regsrc, aluop;
    logic halted, illegal_op, timeout_err;
  } ctl_t;

  typedef enum int {
    B_FETCH, B_FW, B_FWL, B_DEC, B_MEMADR, B_MW, B_FMEMWB, B_MEMWR, B_EXE, B_ALUWB,
    B_BR, B_IMMEX, B_IMMWB, B_JALR, B_SGO, B_UW, B_FTEX, B_TRAP, B_HALT, B_RST
  } bst_t;

  typedef struct {
    string      nm;
    int         d;
    logic [6:0] op;
    logic [3:0] ins;   // {halt_req, mem_ready, uart_done, flpt_done}
    ctl_t       exp;
    logic [31:0] ret;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_a = 1'b0, rstn_b = 1'b0;
  logic [6:0] op_a = '0, op_b = '0;
  logic mr_a = 0, ud_a = 0, fd_a = 0, hr_a = 0;
  logic mr_b = 0, ud_b = 0, fd_b = 0, hr_b = 0;

  logic a_pcw, a_mw, a_irw, a_rw, a_frw, a_pcb, a_iord, a_br, a_ug, a_rors, a_iorf, a_indec;
  logic [1:0] a_sa, a_sb, a_ps;
  logic [2:0] a_rs, a_aop;
  logic a_halt, a_ill, a_tmo;
  logic [15:0] a_ret;
  logic b_pcw, b_mw, b_irw, b_rw, b_frw, b_pcb, b_iord, b_br, b_ug, b_rors, b_iorf, b_indec;
  logic [1:0] b_sa, b_sb, b_ps;
  logic [2:0] b_rs, b_aop;
  logic b_halt, b_ill, b_tmo;
  logic [31:0] b_ret;

  multicycle_ctrl #(.MEM_LAT(3), .USE_READY(0), .TIMEOUT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rstn(rstn_a), .op(op_a), .mem_ready(mr_a), .uart_done(ud_a),
    .flpt_done(fd_a), .halt_req(hr_a),
    .pcwrite(a_pcw), .memwrite(a_mw), .irwrite(a_irw), .regwrite(a_rw), .fregwrite(a_frw),
    .pcbufwrite(a_pcb), .iord(a_iord), .branch(a_br), .uart_go(a_ug), .rors(a_rors),
    .iorf(a_iorf), .indecode(a_indec), .alusrca(a_sa), .alusrcb(a_sb), .pcsrc(a_ps),
    .regsrc(a_rs), .aluop(a_aop), .halted(a_halt), .illegal_op(a_ill),
    .timeout_err(a_tmo), .retired(a_ret));

  multicycle_ctrl #(.MEM_LAT(2), .USE_READY(1), .TIMEOUT(0), .CNT_W(32)) dut_b (
    .clk(clk), .rstn(rstn_b), .op(op_b), .mem_ready(mr_b), .uart_done(ud_b),
    .flpt_done(fd_b), .halt_req(hr_b),
    .pcwrite(b_pcw), .memwrite(b_mw), .irwrite(b_irw), .regwrite(b_rw), .fregwrite(b_frw),
    .pcbufwrite(b_pcb), .iord(b_iord), .branch(b_br), .uart_go(b_ug), .rors(b_rors),
    .iorf(b_iorf), .indecode(b_indec), .alusrca(b_sa), .alusrcb(b_sb), .pcsrc(b_ps),
    .regsrc(b_rs), .aluop(b_aop), .halted(b_halt), .illegal_op(b_ill),
    .timeout_err(b_tmo), .retired(b_ret));

  ctl_t got_a, got_b;
  assign got_a = {a_pcw, a_mw, a_irw, a_rw, a_frw, a_pcb, a_iord, a_br, a_ug, a_rors, a_iorf,
                  a_indec, a_sa, a_sb, a_ps, a_rs, a_aop, a_halt, a_ill, a_tmo};
  assign got_b = {b_pcw, b_mw, b_irw, b_rw, b_frw, b_pcb, b_iord, b_br, b_ug, b_rors, b_iorf,
                  b_indec, b_sa, b_sb, b_ps, b_rs, b_aop, b_halt, b_ill, b_tmo};

  int nvec = 0, nmis = 0;
  vec_t vq[$];
  vec_t sb[$];

  // Expected controls for each state, straight from the output table
  function automatic ctl_t exp_of(bst_t st, logic [6:0] opv, logic [1:0] fl);
    ctl_t e = '0;
    case (st)
      B_FETCH:  begin e.pcwrite = 1; e.pcbufwrite = 1; e.alusrcb = 2'b01; end
      B_FWL:    e.irwrite = 1;
      B_DEC:    begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.indecode = 1; end
      B_MEMADR: begin e.alusrca = 2'b10; e.alusrcb = 2'b10; end
      B_MW:     e.iord = 1;
      B_FMEMWB: e.fregwrite = 1;
      B_MEMWR:  begin e.memwrite = 1; e.iord = 1; e.iorf = (opv == FSW); end
      B_EXE:    begin e.alusrca = 2'b10; e.aluop = 3'b100; end
      B_ALUWB, B_IMMWB: e.regwrite = 1;
      B_BR:     begin e.alusrca = 2'b10; e.pcsrc = 2'b01; e.branch = 1; e.aluop = 3'b111; end
      B_IMMEX:  begin e.alusrca = 2'b10; e.alusrcb = 2'b10; e.aluop = 3'b101; end
      B_JALR: begin
        e.pcwrite = 1; e.regwrite = 1; e.alusrca = 2'b10; e.alusrcb = 2'b10;
        e.regsrc = 3'b011; e.pcsrc = 2'b10;
      end
      B_SGO:    begin e.uart_go = 1; e.rors = 1; end
      B_HALT:   e.halted = 1;
      default: ;
    endcase
    e.illegal_op  = fl[1];
    e.timeout_err = fl[0];
    return e;
  endfunction

  task automatic addv(int d, bst_t st, logic [6:0] opv, int ret, logic [1:0] fl = 2'b00,
                      logic [3:0] ins = 4'b0000);
    vec_t v;
    v.nm  = $sformatf("%s_%0d", st.name(), vq.size());
    v.d   = d;
    v.op  = opv;
    v.ins = ins;
    v.exp = exp_of(st, opv, fl);
    v.ret = ret;
    vq.push_back(v);
  endtask

  // The three fetch-wait cycles of instance A plus DECODE
  task automatic fetch_a(logic [6:0] opv, int ret);
    addv(0, B_FW, opv, ret); addv(0, B_FW, opv, ret);
    addv(0, B_FWL, opv, ret); addv(0, B_DEC, opv, ret);
  endtask

  task automatic compare();
    vec_t v = sb.pop_front();
    ctl_t g = (v.d != 0) ? got_b : got_a;
    logic [31:0] gr = (v.d != 0) ? b_ret : {16'h0, a_ret};
    nvec++;
    if (g !== v.exp || gr !== v.ret) begin
      nmis++;
      $display("FAIL %s (dut %0d): got ctl=%h retired=%0d, required ctl=%h retired=%0d",
               v.nm, v.d, g, gr, v.exp, v.ret);
    end
  endtask

  task automatic run_vecs();
    while (vq.size() > 0) begin
      vec_t v = vq.pop_front();
      if (v.d == 0) begin
        op_a = v.op; {hr_a, mr_a, ud_a, fd_a} = v.ins;
      end else begin
        op_b = v.op; {hr_b, mr_b, ud_b, fd_b} = v.ins;
      end
      sb.push_back(v);
      #1;
      compare();
      @(posedge clk); #1;
    end
  endtask

  // Hold reset for one edge; outputs, flags and retired must read zero throughout
  task automatic reset_a();
    rstn_a = 1'b0;
    addv(0, B_RST, op_a, 0);
    addv(0, B_RST, op_a, 0);
    sb.push_back(vq.pop_front());
    #1; compare();
    @(posedge clk); #1;
    sb.push_back(vq.pop_front());
    compare();
    rstn_a = 1'b1;
  endtask

  initial begin
    addv(0, B_RST, RTYPE, 0);
    sb.push_back(vq.pop_front());
    #2; compare();
    rstn_a = 1'b1;

    addv(0, B_FETCH, RTYPE, 0);
    fetch_a(RTYPE, 0); addv(0, B_EXE, RTYPE, 0); addv(0, B_ALUWB, RTYPE, 0);
    addv(0, B_FETCH, JALR, 1);
    fetch_a(JALR, 1); addv(0, B_JALR, JALR, 1); addv(0, B_FETCH, BTYPE, 2);
    fetch_a(BTYPE, 2); addv(0, B_BR, BTYPE, 2); addv(0, B_FETCH, FSW, 3);
    fetch_a(FSW, 3); addv(0, B_MEMADR, FSW, 3); addv(0, B_MEMWR, FSW, 3);
    addv(0, B_FETCH, SW, 4);
    fetch_a(SW, 4); addv(0, B_MEMADR, SW, 4); addv(0, B_MEMWR, SW, 4);
    addv(0, B_FETCH, SENDB, 5);
    fetch_a(SENDB, 5); addv(0, B_SGO, SENDB, 5); addv(0, B_UW, SENDB, 5);
    addv(0, B_UW, SENDB, 5, 2'b00, 4'b0010); addv(0, B_FETCH, ITYPE, 6);
    fetch_a(ITYPE, 6); addv(0, B_IMMEX, ITYPE, 6);
    addv(0, B_IMMWB, ITYPE, 6, 2'b00, 4'b1000);
    addv(0, B_HALT, ITYPE, 7, 2'b00, 4'b1000);
    addv(0, B_HALT, ITYPE, 7);
    addv(0, B_FETCH, FTYPE, 7);
    fetch_a(FTYPE, 7);
    for (int i = 0; i < 4; i++) addv(0, B_FTEX, FTYPE, 7);
    for (int i = 0; i < 5; i++) addv(0, B_TRAP, FTYPE, 7, 2'b01);
    run_vecs();
    reset_a();

    addv(0, B_FETCH, FTYPE, 0);
    fetch_a(FTYPE, 0);
    for (int i = 0; i < 3; i++) addv(0, B_FTEX, FTYPE, 0);
    addv(0, B_FTEX, FTYPE, 0, 2'b00, 4'b0001);
    addv(0, B_FETCH, BAD, 1);
    fetch_a(BAD, 1);
    for (int i = 0; i < 100; i++) addv(0, B_TRAP, BAD, 1, 2'b10);
    run_vecs();
    #2;
    reset_a();
    addv(0, B_FETCH, RTYPE, 0); addv(0, B_FW, RTYPE, 0);
    run_vecs();

    rstn_b = 1'b1;
    addv(1, B_FETCH, FLW, 0);
    addv(1, B_FW, FLW, 0); addv(1, B_FW, FLW, 0);
    addv(1, B_FWL, FLW, 0, 2'b00, 4'b0100);
    addv(1, B_DEC, FLW, 0); addv(1, B_MEMADR, FLW, 0);
    for (int i = 0; i < 4; i++) addv(1, B_MW, FLW, 0);
    addv(1, B_MW, FLW, 0, 2'b00, 4'b0100);
    addv(1, B_FMEMWB, FLW, 0);
    addv(1, B_FETCH, FLW, 1);
    run_vecs();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
